// File: rtl/fpu_pkg.sv
// fpu_pkg: binary32 field widths, adder working width and canonical constants
// shared by the FPU add datapath and its interface.
package fpu_pkg;

  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int BIAS   = 127;
  localparam int WORK_W = 56;
  localparam int LZC_W  = 6;
  localparam int RND_W  = MAN_W + 4;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] PINF = 32'h7F80_0000;
  localparam logic [31:0] NINF = 32'hFF80_0000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

  // Denormals enter the datapath as signed zeros.
  function automatic fp32_t flush_denorm(input fp32_t x);
    fp32_t r;
    r = x;
    if (x.exp == '0) r.man = '0;
    return r;
  endfunction

endpackage

// File: rtl/fadd_unit_if.sv
// fadd_unit_if: operand/result strobe bundle plus the exported debug datapath
// values of the binary32 adder.
interface fadd_unit_if;
  import fpu_pkg::*;

  logic              in_valid;
  logic [31:0]       src;
  logic [31:0]       sink;
  logic              out_valid;
  logic [31:0]       dest;
  logic              ovf;
  logic [WORK_W-1:0] g_56;
  logic [WORK_W-1:0] l_56;
  logic [WORK_W-1:0] d_56;
  logic [RND_W-1:0]  d_27;
  logic [MAN_W-1:0]  scale;
  logic              ulp;
  logic              guard;
  logic              round;
  logic              sticky;
  logic              flag;

  modport master (
    output in_valid, src, sink,
    input  out_valid, dest, ovf, g_56, l_56, d_56, d_27, scale,
           ulp, guard, round, sticky, flag
  );

  modport slave (
    input  in_valid, src, sink,
    output out_valid, dest, ovf, g_56, l_56, d_56, d_27, scale,
           ulp, guard, round, sticky, flag
  );

endinterface

// File: rtl/fadd_lzc.sv
// fadd_lzc: normalisation shift for the adder. Returns 0 when the carry bit is
// set, otherwise the number of zeros below the carry bit before the first one.
module fadd_lzc
  import fpu_pkg::*;
(
  input  logic [WORK_W-1:0] d_i,
  output logic [LZC_W-1:0]  cnt_o
);

  always_comb begin
    logic found;
    cnt_o = LZC_W'(WORK_W - 1);
    found = 1'b0;
    if (d_i[WORK_W-1]) begin
      cnt_o = '0;
      found = 1'b1;
    end
    for (int i = WORK_W - 2; i >= 0; i--) begin
      if (!found && d_i[i]) begin
        cnt_o = LZC_W'(WORK_W - 2 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fadd_unit.sv
// fadd_unit: binary32 dest = src + sink, round-to-nearest-even, one registered
// stage; alignment, normalisation and rounding values are exported for debug.
module fadd_unit
  import fpu_pkg::*;
(
  input logic        clk,
  input logic        rst,
  fadd_unit_if.slave bus
);

  fp32_t             a_f, b_f, big, sml;
  logic              a_nan, b_nan, a_inf, b_inf, swap, eff_sub;
  logic [EXP_W-1:0]  exp_diff;
  logic [WORK_W-1:0] sig_sml, g_d, l_d, d_d;
  logic [LZC_W-1:0]  lz;
  logic [WORK_W-2:0] nrm;
  logic [RND_W-1:0]  d27_d;
  logic              flag_d;
  logic [MAN_W:0]    frac_sum;
  logic [9:0]        e_pre, e_fin;
  logic [31:0]       dest_d;
  logic              ovf_d;

  logic              out_valid_q, ovf_q, flag_q;
  logic [31:0]       dest_q;
  logic [WORK_W-1:0] g_q, l_q, d_q;
  logic [RND_W-1:0]  d27_q;
  logic [LZC_W-1:0]  scale_q;

  // Swap, align and add/subtract.
  always_comb begin
    a_f      = flush_denorm(bus.src);
    b_f      = flush_denorm(bus.sink);
    swap     = {b_f.exp, b_f.man} > {a_f.exp, a_f.man};
    big      = swap ? b_f : a_f;
    sml      = swap ? a_f : b_f;
    eff_sub  = big.sign ^ sml.sign;
    exp_diff = big.exp - sml.exp;
    g_d      = {1'b0, |big.exp, big.man, {(WORK_W-MAN_W-2){1'b0}}};
    sig_sml  = {1'b0, |sml.exp, sml.man, {(WORK_W-MAN_W-2){1'b0}}};
    l_d      = (exp_diff >= EXP_W'(WORK_W)) ? '0 : (sig_sml >> exp_diff);
    d_d      = eff_sub ? (g_d - l_d) : (g_d + l_d);
  end

  fadd_lzc u_lzc (
    .d_i   (d_d),
    .cnt_o (lz)
  );

  // Normalise, round and resolve special/range cases.
  always_comb begin
    nrm = d_d[WORK_W-2:0] << lz;
    if (d_d[WORK_W-1])
      d27_d = {d_d[55:32], d_d[31], d_d[30], |d_d[29:0]};
    else
      d27_d = {nrm[54:31], nrm[30], nrm[29], |nrm[28:0]};
    flag_d   = d27_d[2] & (d27_d[1] | d27_d[0] | d27_d[3]);
    frac_sum = {1'b0, d27_d[25:3]} + {{MAN_W{1'b0}}, flag_d};
    e_pre    = d_d[WORK_W-1] ? ({2'b0, big.exp} + 10'd1)
                             : ({2'b0, big.exp} - {4'b0, lz});
    e_fin    = e_pre + {9'b0, frac_sum[MAN_W]};

    a_nan = (&a_f.exp) & (|a_f.man);
    b_nan = (&b_f.exp) & (|b_f.man);
    a_inf = (&a_f.exp) & ~(|a_f.man);
    b_inf = (&b_f.exp) & ~(|b_f.man);

    ovf_d  = 1'b0;
    dest_d = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (a_f.sign != b_f.sign))) begin
      dest_d = QNAN;
    end else if (a_inf) begin
      dest_d = a_f;
    end else if (b_inf) begin
      dest_d = b_f;
    end else if (d_d == '0) begin
      dest_d = '0;
    end else if (!e_fin[9] && (e_fin >= 10'd255)) begin
      dest_d = big.sign ? NINF : PINF;
      ovf_d  = 1'b1;
    end else if (e_fin[9] || (e_fin == 10'd0)) begin
      dest_d = '0;
    end else begin
      dest_d = {big.sign, e_fin[EXP_W-1:0], frac_sum[MAN_W-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      dest_q      <= '0;
      ovf_q       <= 1'b0;
      g_q         <= '0;
      l_q         <= '0;
      d_q         <= '0;
      d27_q       <= '0;
      scale_q     <= '0;
      flag_q      <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        dest_q  <= dest_d;
        ovf_q   <= ovf_d;
        g_q     <= g_d;
        l_q     <= l_d;
        d_q     <= d_d;
        d27_q   <= d27_d;
        scale_q <= lz;
        flag_q  <= flag_d;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.dest      = dest_q;
  assign bus.ovf       = ovf_q;
  assign bus.g_56      = g_q;
  assign bus.l_56      = l_q;
  assign bus.d_56      = d_q;
  assign bus.d_27      = d27_q;
  assign bus.scale     = {{(MAN_W-LZC_W){1'b0}}, scale_q};
  assign bus.ulp       = d27_q[3];
  assign bus.guard     = d27_q[2];
  assign bus.round     = d27_q[1];
  assign bus.sticky    = d27_q[0];
  assign bus.flag      = flag_q;

endmodule

// File: tb/tb_fadd_unit.sv
// tb_fadd_unit: scoreboard bench for fadd_unit; expected sums come from an
// exact wide-integer add followed by round-to-nearest-even.
module tb_fadd_unit;

  logic clk;
  logic rst;

  fadd_unit_if bus ();

  fadd_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        o;
    bit          dbg;
    logic        f;
    logic        g;
    logic [22:0] s;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] last_dest;

  logic [31:0] specials [8] = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                                32'h7FC0_0000, 32'h7F81_2345, 32'h0001_2345, 32'h8040_0000};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, expv);
  endtask

  // Exact sum on a common binary point, then round to 24 significant bits.
  function automatic void ref_add(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic o);
    int ea, eb, emin, p, sh, e;
    logic [23:0] ma, mb;
    logic [319:0] xa, xb, mag, rem, half, kept;
    logic sr;
    o  = 1'b0;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0) ||
        (ea == 255 && eb == 255 && a[31] != b[31])) begin
      r = 32'h7FC0_0000;
      return;
    end
    if (ea == 255) begin r = a; return; end
    if (eb == 255) begin r = b; return; end
    ma   = (ea == 0) ? 24'd0 : {1'b1, a[22:0]};
    mb   = (eb == 0) ? 24'd0 : {1'b1, b[22:0]};
    emin = (ea < eb) ? ea : eb;
    xa   = 320'(ma) << (ea - emin);
    xb   = 320'(mb) << (eb - emin);
    if (a[31] == b[31]) begin mag = xa + xb; sr = a[31]; end
    else if (xa >= xb)  begin mag = xa - xb; sr = a[31]; end
    else                begin mag = xb - xa; sr = b[31]; end
    if (mag == 0) begin r = 32'h0; return; end
    p = 0;
    for (int i = 0; i < 320; i++) if (mag[i]) p = i;
    e = emin - 23 + p;
    if (p > 23) begin
      sh   = p - 23;
      kept = mag >> sh;
      rem  = mag & ((320'd1 << sh) - 320'd1);
      half = 320'd1 << (sh - 1);
      if (rem > half || (rem == half && kept[0])) kept = kept + 320'd1;
      if (kept[24]) begin kept = kept >> 1; e = e + 1; end
    end else begin
      kept = mag << (23 - p);
    end
    if (e >= 255) begin
      r = {sr, 8'hFF, 23'h0};
      o = 1'b1;
    end else if (e <= 0) begin
      r = 32'h0;
    end else begin
      r = {sr, 8'(e), kept[22:0]};
    end
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] d,
                      input logic o, input bit dbg, input logic f, input logic g,
                      input logic [22:0] s);
    exp_t e;
    e.a = a; e.b = b; e.d = d; e.o = o; e.dbg = dbg; e.f = f; e.g = g; e.s = s;
    sb.push_back(e);
    last_dest    = d;
    bus.in_valid = 1'b1;
    bus.src      = a;
    bus.sink     = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_rand(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    logic        o;
    ref_add(a, b, d, o);
    send(a, b, d, o, 1'b0, 1'b0, 1'b0, 23'd0);
  endtask

  // Idle cycles scramble the operands so a missing hold shows up on dest.
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      bus.in_valid = 1'b0;
      bus.src      = $urandom;
      bus.sink     = $urandom;
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst !== 1'b1 && bus.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL spurious out_valid: got dest %08h with no request outstanding", bus.dest);
      end else begin
        e = sb.pop_front();
        chk($sformatf("dest %08h+%08h", e.a, e.b), 64'(bus.dest), 64'(e.d));
        chk($sformatf("ovf %08h+%08h", e.a, e.b), 64'(bus.ovf), 64'(e.o));
        if (e.dbg) begin
          chk($sformatf("flag %08h+%08h", e.a, e.b), 64'(bus.flag), 64'(e.f));
          chk($sformatf("guard %08h+%08h", e.a, e.b), 64'(bus.guard), 64'(e.g));
          chk($sformatf("scale %08h+%08h", e.a, e.b), 64'(bus.scale), 64'(e.s));
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d results outstanding", sb.size());
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.src      = '0;
    bus.sink     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset dest", 64'(bus.dest), 64'h0);
    chk("reset ovf", 64'(bus.ovf), 64'h0);
    chk("reset out_valid", 64'(bus.out_valid), 64'h0);
    rst = 1'b0;

    //           src           sink          dest          ovf  dbg   flag  guard scale
    send(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 23'd0);
    idle(1);
    send(32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 23'd0);
    // 2^54 - (2^54 - 2^30) leaves only bit 30: 24 zeros below the carry bit.
    send(32'h4000_0000, 32'hBFFF_FFFF, 32'h3400_0000, 1'b0, 1'b1, 1'b0, 1'b0, 23'd24);
    send(32'h3FA0_0005, 32'hBFA0_0000, 32'h3520_0000, 1'b0, 1'b1, 1'b0, 1'b0, 23'd21);
    send(32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, 1'b0, 1'b1, 1'b0, 1'b1, 23'd0);
    send(32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002, 1'b0, 1'b1, 1'b1, 1'b1, 23'd0);
    send(32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 1'b1, 1'b1, 1'b0, 1'b0, 23'd0);
    send(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 1'b0, 1'b0, 1'b0, 23'd0);
    send(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 1'b0, 1'b0, 1'b0, 1'b0, 23'd0);
    send(32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, 1'b0, 1'b0, 1'b0, 1'b0, 23'd0);
    send(32'h0000_0001, 32'hBF80_0000, 32'hBF80_0000, 1'b0, 1'b0, 1'b0, 1'b0, 23'd0);
    send(32'h0080_0001, 32'h8080_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 23'd0);
    idle(2);
    chk("hold dest while idle", 64'(bus.dest), 64'(last_dest));

    send_rand(32'h4049_0FDB, 32'h402D_F854);
    send_rand(32'hC120_0000, 32'h3F00_0000);
    send_rand(32'h3DCC_CCCD, 32'h3E4C_CCCD);
    send_rand(32'h42F6_0000, 32'hC2F5_0000);
    idle(1);

    for (int i = 0; i < 2000; i++) begin
      logic [31:0] a, b;
      int ea, eb, mode;
      ea   = int'($urandom_range(1, 254));
      mode = int'($urandom_range(0, 3));
      if (mode <= 1) begin
        eb = int'($urandom_range(1, 254));
      end else begin
        eb = ea + int'($urandom_range(0, 4)) - 2;
        if (eb < 1)   eb = 1;
        if (eb > 254) eb = 254;
      end
      a = {1'($urandom), 8'(ea), 23'($urandom)};
      b = {1'($urandom), 8'(eb), 23'($urandom)};
      if (mode == 3 && $urandom_range(0, 1) == 0) b = {~a[31], a[30:0]};
      if ($urandom_range(0, 15) == 0) a = specials[$urandom_range(0, 7)];
      if ($urandom_range(0, 15) == 0) b = specials[$urandom_range(0, 7)];
      send_rand(a, b);
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    idle(3);
    chk("hold dest after sweep", 64'(bus.dest), 64'(last_dest));
    chk("scoreboard drained", 64'(sb.size()), 64'h0);

    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.src      = 32'h3F80_0000;
    bus.sink     = 32'h4000_0000;
    @(posedge clk);
    #1;
    chk("mid-run reset dest", 64'(bus.dest), 64'h0);
    chk("mid-run reset d_56", 64'(bus.d_56), 64'h0);
    chk("mid-run reset out_valid", 64'(bus.out_valid), 64'h0);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
